// File: rtl/hazard_pkg.sv
// hazard_pkg: shared types and constants for the pipeline hazard controller.
package hazard_pkg;

  // Width of a RISC-V register index and the hard-wired zero register.
  localparam int REG_W = 5;
  localparam logic [REG_W-1:0] REG_X0 = '0;

  // Controller sequencing states.
  typedef enum logic [1:0] {
    RUN     = 2'd0,
    LWSTALL = 2'd1,
    MEMWAIT = 2'd2
  } hazard_state_e;

  // True when a load destination feeds a source operand. x0 is excluded
  // because x0 always reads as zero and so never carries a dependency.
  function automatic logic reg_dep(input logic [REG_W-1:0] rd,
                                   input logic [REG_W-1:0] rs);
    return (rd != REG_X0) && (rd == rs);
  endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt: saturating event counter with synchronous reset.
// Instantiated by hazard_ctrl only when HAZARD_PERF_EN is defined.
module hazard_perf_cnt #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Count qualifying cycles and stop at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: stall/flush controller for the 5-stage RISC-V pipeline.
// Handles one-bubble load-use stalls, memory-wait freezes and a sticky
// memory-timeout flag. Optional macro HAZARD_PERF_EN adds two saturating
// performance counters; without it both counter outputs are tied to zero.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] IF_ID_RegisterRs1,
  input  logic [REG_W-1:0] IF_ID_RegisterRs2,
  input  logic             ID_EX_MemRead,
  input  logic [REG_W-1:0] ID_EX_RegisterRd,
  input  logic             Branch_taken,
  input  logic             EX_MEM_MemRead,
  input  logic             EX_MEM_MemWrite,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_Flush_lwstall,
  output logic             pipe_hold,
  output logic             mem_err,
  output logic [CNT_W-1:0] lwstall_cnt,
  output logic [CNT_W-1:0] memwait_cnt
);

  localparam int WAIT_W = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

  hazard_state_e     state;
  hazard_state_e     state_next;
  logic              lu_hit;
  logic              mem_busy;
  logic [WAIT_W-1:0] wait_cnt;

  // Raw hazard conditions decoded from the current pipeline contents.
  always_comb begin
    lu_hit   = ID_EX_MemRead &&
               (reg_dep(ID_EX_RegisterRd, IF_ID_RegisterRs1) ||
                reg_dep(ID_EX_RegisterRd, IF_ID_RegisterRs2));
    mem_busy = (EX_MEM_MemRead || EX_MEM_MemWrite) && !mem_ready;
  end

  // Next-state sequencing; LWSTALL always lasts a single cycle.
  always_comb begin
    state_next = state;
    case (state)
      RUN: begin
        if (mem_busy) begin
          state_next = MEMWAIT;
        end else if (lu_hit) begin
          state_next = LWSTALL;
        end else begin
          state_next = RUN;
        end
      end
      LWSTALL: begin
        state_next = mem_busy ? MEMWAIT : RUN;
      end
      MEMWAIT: begin
        state_next = mem_busy ? MEMWAIT : RUN;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // Mealy stall/flush outputs with priority memory wait > load-use > branch.
  // A load-use hit seen while already in LWSTALL is the same load that just
  // got its bubble, so it is ignored and the branch is re-evaluated.
  always_comb begin
    PCWrite          = 1'b1;
    IF_ID_Write      = 1'b1;
    IF_ID_Flush      = 1'b0;
    ID_Flush_lwstall = 1'b0;
    pipe_hold        = 1'b0;
    if (reset) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
    end else if (mem_busy) begin
      PCWrite     = 1'b0;
      IF_ID_Write = 1'b0;
      pipe_hold   = 1'b1;
    end else if (lu_hit && (state != LWSTALL)) begin
      PCWrite          = 1'b0;
      IF_ID_Write      = 1'b0;
      ID_Flush_lwstall = 1'b1;
    end else if (Branch_taken) begin
      IF_ID_Flush = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Consecutive wait-cycle counter. Every busy cycle is a wait cycle, including
  // the first one whose state register still reads RUN or LWSTALL, because that
  // cycle always leads into MEMWAIT. Any non-busy cycle ends the wait and clears.
  always_ff @(posedge clk) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (mem_busy) begin
      if (wait_cnt != WAIT_MAX) begin
        wait_cnt <= wait_cnt + WAIT_W'(1);
      end
    end else begin
      wait_cnt <= '0;
    end
  end

  // Sticky timeout flag: set once the wait exceeds MEM_TIMEOUT cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_err <= 1'b0;
    end else if (mem_busy && (wait_cnt == WAIT_MAX)) begin
      mem_err <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  hazard_perf_cnt #(
    .W(CNT_W)
  ) u_lwstall_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (ID_Flush_lwstall),
    .count(lwstall_cnt)
  );

  hazard_perf_cnt #(
    .W(CNT_W)
  ) u_memwait_cnt (
    .clk  (clk),
    .reset(reset),
    .inc  (pipe_hold),
    .count(memwait_cnt)
  );
`else
  assign lwstall_cnt = '0;
  assign memwait_cnt = '0;
`endif

endmodule
